// File: rtl/text_scroll_if.sv
// Control and status bundle between the frame sequencer and the scroll controller.
interface text_scroll_if;
  logic       frame_start;
  logic       enable;
  logic [3:0] speed;
  logic       dir;
  logic       restart;
  logic [5:0] x_shift;
  logic [3:0] head;
  logic [3:0] slot0_idx;
  logic [3:0] slot1_idx;
  logic [3:0] slot2_idx;
  logic [3:0] slot3_idx;
  logic       running;
  logic       cfg_upd;

  modport master (
    output frame_start, enable, speed, dir, restart,
    input  x_shift, head, slot0_idx, slot1_idx, slot2_idx, slot3_idx, running, cfg_upd
  );

  modport slave (
    input  frame_start, enable, speed, dir, restart,
    output x_shift, head, slot0_idx, slot1_idx, slot2_idx, slot3_idx, running, cfg_upd
  );
endinterface

// File: rtl/text_scroll_ctrl.sv
// Frame-synchronous scroll sequencer for the four-slot glyph text layer.
// Every configuration output moves only on a frame_start edge, so the pixel path never tears.
module text_scroll_ctrl #(
  parameter int unsigned MSG_LEN     = 8,
  parameter int unsigned PITCH       = 64,
  parameter int unsigned STEP_PX     = 2,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input logic          clk,
  input logic          rst_n,
  text_scroll_if.slave bus
);

  localparam int unsigned XW     = 6;
  localparam int unsigned HW     = 4;
  localparam int unsigned SW     = XW + 1;
  localparam int unsigned NSLOTS = 4;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e          state_q, state_d;
  logic [3:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic            restart_pend_q, restart_pend_d;
  logic [XW-1:0]   x_shift_q, x_shift_d;
  logic [HW-1:0]   head_q, head_d;
  logic [HW-1:0]   slot_q [NSLOTS];
  logic [HW-1:0]   slot_d [NSLOTS];
  logic            running_q, running_d;
  logic            cfg_upd_q, cfg_upd_d;
  logic [SW-1:0]   step_sum;

  // Compare-and-wrap add, MSG_LEN need not be a power of two.
  function automatic logic [HW-1:0] wrap_add(input logic [HW-1:0] h, input int unsigned n);
    logic [HW:0] s;
    s = (HW+1)'(h) + (HW+1)'(n);
    if (s >= (HW+1)'(MSG_LEN)) s = s - (HW+1)'(MSG_LEN);
    return s[HW-1:0];
  endfunction

  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    restart_pend_d = restart_pend_q | bus.restart;
    x_shift_d      = x_shift_q;
    head_d         = head_q;
    step_sum       = SW'(x_shift_q) + SW'(STEP_PX);

    if (bus.frame_start) begin
      if (restart_pend_q || bus.restart) begin
        x_shift_d      = '0;
        head_d         = '0;
        frame_cnt_d    = '0;
        hold_cnt_d     = '0;
        restart_pend_d = 1'b0;
        state_d        = bus.enable ? RUN : IDLE;
      end else if (!bus.enable) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            state_d     = RUN;
            frame_cnt_d = '0;
          end
          RUN: begin
            // >= rather than == so lowering speed mid-count steps at once
            if (frame_cnt_q < bus.speed) begin
              frame_cnt_d = frame_cnt_q + 4'd1;
            end else begin
              frame_cnt_d = '0;
              if (!bus.dir) begin
                if (step_sum == SW'(PITCH)) begin
                  x_shift_d  = '0;
                  head_d     = (head_q == HW'(MSG_LEN - 1)) ? '0 : head_q + HW'(1);
                  hold_cnt_d = '0;
                  state_d    = HOLD;
                end else begin
                  x_shift_d = step_sum[XW-1:0];
                end
              end else if (x_shift_q != '0) begin
                x_shift_d = XW'(SW'(x_shift_q) - SW'(STEP_PX));
              end else begin
                x_shift_d  = XW'(PITCH - STEP_PX);
                head_d     = (head_q == '0) ? HW'(MSG_LEN - 1) : head_q - HW'(1);
                hold_cnt_d = '0;
                state_d    = HOLD;
              end
            end
          end
          HOLD: begin
            if (hold_cnt_q == 8'(HOLD_FRAMES - 1)) begin
              state_d     = RUN;
              frame_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    for (int unsigned i = 0; i < NSLOTS; i++) slot_d[i] = wrap_add(head_d, i);
    running_d = (state_d != IDLE);
    cfg_upd_d = bus.frame_start && ((x_shift_d != x_shift_q) || (head_d != head_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      frame_cnt_q    <= '0;
      hold_cnt_q     <= '0;
      restart_pend_q <= 1'b0;
      x_shift_q      <= '0;
      head_q         <= '0;
      for (int unsigned i = 0; i < NSLOTS; i++) slot_q[i] <= HW'(i);
      running_q      <= 1'b0;
      cfg_upd_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      restart_pend_q <= restart_pend_d;
      x_shift_q      <= x_shift_d;
      head_q         <= head_d;
      for (int unsigned i = 0; i < NSLOTS; i++) slot_q[i] <= slot_d[i];
      running_q      <= running_d;
      cfg_upd_q      <= cfg_upd_d;
    end
  end

  assign bus.x_shift   = x_shift_q;
  assign bus.head      = head_q;
  assign bus.slot0_idx = slot_q[0];
  assign bus.slot1_idx = slot_q[1];
  assign bus.slot2_idx = slot_q[2];
  assign bus.slot3_idx = slot_q[3];
  assign bus.running   = running_q;
  assign bus.cfg_upd   = cfg_upd_q;

endmodule
